// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side buffer behind a UART RX block.
// Each rising edge of the UART's read-enable level marks one received frame.
// The frame is masked to the configured data length and queued in a
// first-word-fall-through FIFO. The FIFO reports its occupancy and has a sticky
// overflow flag.
//
// Host handshake: Valid_Out is high whenever the FIFO holds a word, and Data_Out
// is then the oldest word. A word is consumed on a rising clock edge where
// Valid_Out and Ready_In are both high. Valid_Out never depends combinationally
// on Ready_In. Ready_In while Valid_Out is low is ignored.
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 9,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  Clk_In,
    input  logic                  Reset_In,
    input  logic [2:0]            UART_Num_Data_Bits_In,
    input  logic                  Enable_In,
    input  logic [DATA_WIDTH-1:0] RX_Data_In,
    input  logic                  RX_Read_Enable_In,
    output logic [DATA_WIDTH-1:0] Data_Out,
    output logic                  Valid_Out,
    input  logic                  Ready_In,
    output logic [ADDR_WIDTH:0]   Count_Out,
    output logic                  Full_Out,
    output logic                  Overflow_Out,
    input  logic                  Clear_Overflow_In
);

    localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

    // The enable comes from the RX baud domain, so it crosses through a
    // two-flop synchroniser. prev keeps the last synchronised value for
    // rising-edge detection. All three flops reset to 1, so an enable that is
    // already high when reset releases does not look like a new frame.
    logic sync1;
    logic sync2;
    logic prev;
    logic push_req;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;

    logic [3:0]            data_bits;
    logic [DATA_WIDTH-1:0] mask;
    logic [DATA_WIDTH-1:0] masked_data;

    logic pop;
    logic push_ok;
    logic overflow_set;
    logic overflow;

    // Synchronise the frame enable and remember its previous value.
    always_ff @(posedge Clk_In) begin
        if (Reset_In) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= RX_Read_Enable_In;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // A single cycle of push_req is produced per rising edge, however long the enable stays high.
    assign push_req = sync2 & ~prev;

    // Build a mask that keeps only the configured number of data bits.
    always_comb begin
        data_bits = 4'd9;
        mask      = '0;
        case (UART_Num_Data_Bits_In)
            3'd0:    data_bits = 4'd5;
            3'd1:    data_bits = 4'd6;
            3'd2:    data_bits = 4'd7;
            3'd3:    data_bits = 4'd8;
            default: data_bits = 4'd9;
        endcase
        for (int i = 0; i < DATA_WIDTH; i++) begin
            mask[i] = (i < int'(data_bits));
        end
    end

    // RX data stays stable while the enable is high, so it is sampled directly without synchronising.
    assign masked_data = RX_Data_In & mask;

    assign Valid_Out    = (count != '0);
    assign Full_Out     = (count == FULL_COUNT);
    assign pop          = Valid_Out & Ready_In;
    // A pop in the same cycle frees the head slot, so a full FIFO can still accept the word.
    assign push_ok      = push_req & Enable_In & (~Full_Out | pop);
    assign overflow_set = push_req & Enable_In & Full_Out & ~pop;

    // Storage array. It is cleared on reset so the head reads as zero after reset.
    always_ff @(posedge Clk_In) begin
        if (Reset_In) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_ok) begin
            mem[wr_ptr] <= masked_data;
        end
    end

    // Pointers wrap modulo DEPTH. The count moves by at most one per cycle.
    always_ff @(posedge Clk_In) begin
        if (Reset_In) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow flag. Setting it takes priority over the host's clear.
    always_ff @(posedge Clk_In) begin
        if (Reset_In) begin
            overflow <= 1'b0;
        end else if (overflow_set) begin
            overflow <= 1'b1;
        end else if (Clear_Overflow_In) begin
            overflow <= 1'b0;
        end
    end

    assign Data_Out     = mem[rd_ptr];
    assign Count_Out    = count;
    assign Overflow_Out = overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo. Inputs are driven, and outputs sampled,
// 1 ns after each rising clock edge.
module tb_uart_rx_fifo;

    logic       clk;
    logic       reset_in;
    logic [2:0] num_bits;
    logic       enable_in;
    logic [8:0] rx_data;
    logic       rx_en;
    logic [8:0] data_out;
    logic       valid_out;
    logic       ready_in;
    logic [4:0] count_out;
    logic       full_out;
    logic       overflow_out;
    logic       clear_ovf;

    int checks;
    int failures;

    uart_rx_fifo #(.DATA_WIDTH(9), .DEPTH(16), .ADDR_WIDTH(4)) dut (
        .Clk_In                (clk),
        .Reset_In              (reset_in),
        .UART_Num_Data_Bits_In (num_bits),
        .Enable_In             (enable_in),
        .RX_Data_In            (rx_data),
        .RX_Read_Enable_In     (rx_en),
        .Data_Out              (data_out),
        .Valid_Out             (valid_out),
        .Ready_In              (ready_in),
        .Count_Out             (count_out),
        .Full_Out              (full_out),
        .Overflow_Out          (overflow_out),
        .Clear_Overflow_In     (clear_ovf)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Driver tasks
    task automatic send_frame(input logic [8:0] data, input int hold);
        rx_data = data;
        rx_en   = 1'b1;
        repeat (hold) tick();
        rx_en = 1'b0;
        repeat (3) tick();
    endtask

    task automatic pop_one();
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
    endtask

    // Tests
    task automatic test_reset();
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", valid_out); end
        checks++; if (count_out !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count_out); end
        checks++; if (full_out !== 1'b0) begin failures++; $display("FAIL reset_full got=%0h exp=0", full_out); end
        checks++; if (overflow_out !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0h exp=0", overflow_out); end
        checks++; if (data_out !== 9'h000) begin failures++; $display("FAIL reset_data got=%0h exp=0", data_out); end
    endtask

    task automatic test_single_frame();
        num_bits = 3'd3;
        rx_data  = 9'h1A5;
        rx_en    = 1'b1;
        tick();
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL single_lat1 got=%0h exp=0", valid_out); end
        tick();
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL single_lat2 got=%0h exp=0", valid_out); end
        tick();
        checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL single_lat3 got=%0h exp=1", valid_out); end
        checks++; if (data_out !== 9'h0A5) begin failures++; $display("FAIL single_data got=%0h exp=0a5", data_out); end
        checks++; if (count_out !== 5'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", count_out); end
        tick();
        rx_en = 1'b0;
        repeat (3) tick();
        checks++; if (count_out !== 5'd1) begin failures++; $display("FAIL single_one_push got=%0d exp=1", count_out); end
        pop_one();
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL single_pop_valid got=%0h exp=0", valid_out); end
        checks++; if (count_out !== 5'd0) begin failures++; $display("FAIL single_pop_count got=%0d exp=0", count_out); end
    endtask

    task automatic test_masking();
        logic [8:0] exp_q[$];
        num_bits = 3'd0; send_frame(9'h1FF, 2); exp_q.push_back(9'h01F);
        num_bits = 3'd2; send_frame(9'h1FF, 2); exp_q.push_back(9'h07F);
        num_bits = 3'd4; send_frame(9'h1FF, 2); exp_q.push_back(9'h1FF);
        checks++; if (count_out !== 5'd3) begin failures++; $display("FAIL mask_count got=%0d exp=3", count_out); end
        // A later mode change must not alter words already stored.
        num_bits = 3'd0;
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++; if (data_out !== exp_q[i]) begin failures++; $display("FAIL mask_word%0d got=%0h exp=%0h", i, data_out, exp_q[i]); end
            pop_one();
        end
        checks++; if (count_out !== 5'd0) begin failures++; $display("FAIL mask_drain got=%0d exp=0", count_out); end
    endtask

    task automatic test_ready_empty();
        ready_in = 1'b1;
        repeat (3) tick();
        ready_in = 1'b0;
        checks++; if (count_out !== 5'd0) begin failures++; $display("FAIL empty_pop_count got=%0d exp=0", count_out); end
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL empty_pop_valid got=%0h exp=0", valid_out); end
    endtask

    task automatic test_fill_overflow();
        num_bits = 3'd4;
        for (int v = 1; v <= 16; v++) send_frame(9'(v), 2);
        checks++; if (overflow_out !== 1'b0) begin failures++; $display("FAIL fill_no_ovf got=%0h exp=0", overflow_out); end
        checks++; if (full_out !== 1'b1) begin failures++; $display("FAIL fill_full16 got=%0h exp=1", full_out); end
        send_frame(9'd17, 2);
        checks++; if (full_out !== 1'b1) begin failures++; $display("FAIL ovf_full got=%0h exp=1", full_out); end
        checks++; if (count_out !== 5'd16) begin failures++; $display("FAIL ovf_count got=%0d exp=16", count_out); end
        checks++; if (overflow_out !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0h exp=1", overflow_out); end
        for (int v = 1; v <= 16; v++) begin
            checks++; if (data_out !== 9'(v)) begin failures++; $display("FAIL fill_order%0d got=%0h exp=%0h", v, data_out, 9'(v)); end
            pop_one();
        end
        checks++; if (count_out !== 5'd0) begin failures++; $display("FAIL fill_drain got=%0d exp=0", count_out); end
        checks++; if (overflow_out !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0h exp=1", overflow_out); end
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        checks++; if (overflow_out !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%0h exp=0", overflow_out); end
    endtask

    task automatic test_full_push_pop();
        logic [8:0] exp_q[$];
        num_bits = 3'd4;
        for (int i = 0; i < 16; i++) begin
            send_frame(9'h020 + 9'(i), 2);
            if (i > 0) exp_q.push_back(9'h020 + 9'(i));
        end
        exp_q.push_back(9'h055);
        checks++; if (full_out !== 1'b1) begin failures++; $display("FAIL pp_full_before got=%0h exp=1", full_out); end
        // push_req is high in the cycle after the second edge, so the pop is placed in that cycle.
        rx_data = 9'h055;
        rx_en   = 1'b1;
        tick();
        tick();
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        rx_en    = 1'b0;
        checks++; if (count_out !== 5'd16) begin failures++; $display("FAIL pp_count got=%0d exp=16", count_out); end
        checks++; if (overflow_out !== 1'b0) begin failures++; $display("FAIL pp_no_ovf got=%0h exp=0", overflow_out); end
        repeat (3) tick();
        for (int i = 0; i < 16; i++) begin
            checks++; if (data_out !== exp_q[i]) begin failures++; $display("FAIL pp_order%0d got=%0h exp=%0h", i, data_out, exp_q[i]); end
            pop_one();
        end
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL pp_drain got=%0h exp=0", valid_out); end
    endtask

    task automatic test_disabled();
        enable_in = 1'b0;
        send_frame(9'h0AA, 3);
        enable_in = 1'b1;
        checks++; if (count_out !== 5'd0) begin failures++; $display("FAIL dis_count got=%0d exp=0", count_out); end
        checks++; if (overflow_out !== 1'b0) begin failures++; $display("FAIL dis_ovf got=%0h exp=0", overflow_out); end
    endtask

    task automatic test_long_enable();
        num_bits = 3'd3;
        send_frame(9'h0C3, 20);
        checks++; if (count_out !== 5'd1) begin failures++; $display("FAIL long_count got=%0d exp=1", count_out); end
        checks++; if (data_out !== 9'h0C3) begin failures++; $display("FAIL long_data got=%0h exp=0c3", data_out); end
        pop_one();
        checks++; if (count_out !== 5'd0) begin failures++; $display("FAIL long_drain got=%0d exp=0", count_out); end
    endtask

    task automatic test_reset_midstream();
        num_bits = 3'd3;
        for (int i = 0; i < 5; i++) send_frame(9'h011 + 9'(i), 2);
        checks++; if (count_out !== 5'd5) begin failures++; $display("FAIL mid_count5 got=%0d exp=5", count_out); end
        rx_data = 9'h077;
        rx_en   = 1'b1;
        tick();
        reset_in = 1'b1;
        tick();
        checks++; if (count_out !== 5'd0) begin failures++; $display("FAIL mid_rst_count got=%0d exp=0", count_out); end
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%0h exp=0", valid_out); end
        checks++; if (data_out !== 9'h000) begin failures++; $display("FAIL mid_rst_data got=%0h exp=0", data_out); end
        tick();
        reset_in = 1'b0;
        repeat (5) tick();
        checks++; if (count_out !== 5'd0) begin failures++; $display("FAIL mid_no_capture got=%0d exp=0", count_out); end
        rx_en = 1'b0;
        repeat (3) tick();
        send_frame(9'h03C, 2);
        checks++; if (count_out !== 5'd1) begin failures++; $display("FAIL mid_next_count got=%0d exp=1", count_out); end
        checks++; if (data_out !== 9'h03C) begin failures++; $display("FAIL mid_next_data got=%0h exp=03c", data_out); end
        pop_one();
    endtask

    // Sequence and final report
    initial begin
        checks    = 0;
        failures  = 0;
        reset_in  = 1'b1;
        num_bits  = 3'd3;
        enable_in = 1'b1;
        rx_data   = '0;
        rx_en     = 1'b0;
        ready_in  = 1'b0;
        clear_ovf = 1'b0;
        repeat (3) tick();
        test_reset();
        reset_in = 1'b0;
        repeat (3) tick();
        test_single_frame();
        test_masking();
        test_ready_empty();
        test_fill_overflow();
        test_full_push_pop();
        test_disabled();
        test_long_enable();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
